// File: rtl/stage4ma_agu.sv
// Memory Address stage: base + signed-offset address generation, post-increment writeback,
// range fault detection, and a 2-entry skid buffer between EX and MO.
module stage4ma_agu #(
  parameter int PC_W      = 12,
  parameter int ADDR_W    = 12,
  parameter int OFF_W     = 8,
  parameter int MEM_LIMIT = 4095,
  parameter int FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [1:0]        op_in,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [OFF_W-1:0]  off_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [1:0]        op_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [ADDR_W-1:0] wb_out,
  output logic              wb_en_out,
  output logic              fault_out,
  output logic [FCNT_W-1:0] fault_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wb;
    logic              fault;
  } entry_t;

  localparam logic [1:0]        OP_LOAD    = 2'b01;
  localparam logic [1:0]        OP_STORE   = 2'b10;
  localparam logic [1:0]        OP_POSTINC = 2'b11;
  localparam logic [ADDR_W:0]   LIMIT_X    = (ADDR_W+1)'(MEM_LIMIT);
  localparam logic [FCNT_W-1:0] FCNT_MAX   = '1;

  state_e            state_q, state_d;
  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;
  logic              in_ready_q, in_ready_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [ADDR_W:0]   sum;
  logic [ADDR_W-1:0] sum_lo;
  logic              base_over;
  logic              sum_over;
  entry_t            new_entry;
  logic              accept;
  logic              emit;

  // Widened compares keep the limit check well-formed even when MEM_LIMIT is the top address.
  always_comb begin
    sum       = {1'b0, base_in} + {{(ADDR_W+1-OFF_W){off_in[OFF_W-1]}}, off_in};
    sum_lo    = sum[ADDR_W-1:0];
    base_over = {1'b0, base_in} > LIMIT_X;
    sum_over  = {1'b0, sum_lo} > LIMIT_X;

    new_entry.pc    = pc_in;
    new_entry.op    = op_in;
    new_entry.addr  = base_in;
    new_entry.wb    = base_in;
    new_entry.fault = 1'b0;
    case (op_in)
      OP_LOAD, OP_STORE: begin
        new_entry.addr  = sum_lo;
        new_entry.fault = sum[ADDR_W] | sum_over;
      end
      OP_POSTINC: begin
        new_entry.wb    = sum_lo;
        new_entry.fault = sum[ADDR_W] | base_over | sum_over;
      end
      default: ;
    endcase
  end

  assign accept = in_valid & in_ready_q;
  assign emit   = (state_q != S_EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fcnt_d  = fcnt_q;

    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            head_d  = new_entry;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          case ({accept, emit})
            2'b10: begin
              tail_d  = new_entry;
              state_d = S_TWO;
            end
            2'b01: state_d = S_EMPTY;
            2'b11: head_d = new_entry;
            default: ;
          endcase
        end
        S_TWO: begin
          if (emit) begin
            head_d  = tail_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase

      if (accept && new_entry.fault && (fcnt_q != FCNT_MAX)) begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign pc_out    = head_q.pc;
  assign op_out    = head_q.op;
  assign addr_out  = head_q.addr;
  assign wb_out    = head_q.wb;
  assign fault_out = head_q.fault;
  assign wb_en_out = (head_q.op == OP_POSTINC) & ~head_q.fault;
  assign fault_cnt = fcnt_q;

endmodule

// File: tb/tb_stage4ma_agu.sv
// Bench for stage4ma_agu: directed scenarios plus a random soak, all checked against a
// queue-based reference model of the address stage.
module tb_stage4ma_agu;

  localparam int LIMIT = 12'h7FF;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] pc_in;
  logic [1:0]  op_in;
  logic [11:0] base_in;
  logic [7:0]  off_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] pc_out;
  logic [1:0]  op_out;
  logic [11:0] addr_out;
  logic [11:0] wb_out;
  logic        wb_en_out;
  logic        fault_out;
  logic [7:0]  fault_cnt;

  typedef struct {
    logic [11:0] pc;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [11:0] wb;
    logic        wben;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   exp_fcnt;
  int   n_cmp;
  int   n_bad;
  bit   chk_en;

  stage4ma_agu #(
    .PC_W(12), .ADDR_W(12), .OFF_W(8), .MEM_LIMIT(LIMIT), .FCNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .op_in(op_in), .base_in(base_in), .off_in(off_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .op_out(op_out), .addr_out(addr_out), .wb_out(wb_out),
    .wb_en_out(wb_en_out), .fault_out(fault_out), .fault_cnt(fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model works in plain integers so range overflow shows up as s<0 or s>4095.
  function automatic exp_t model(input logic [11:0] pc, input logic [1:0] op,
                                 input logic [11:0] base, input logic [7:0] off);
    exp_t e;
    int   s;
    int   lo;
    bit   oor;
    s     = int'(base) + int'($signed(off));
    oor   = (s < 0) || (s > 4095);
    lo    = s & 32'hFFF;
    e.pc  = pc;
    e.op  = op;
    e.addr = base;
    e.wb   = base;
    e.fault = 1'b0;
    if (op == 2'b01 || op == 2'b10) begin
      e.addr  = 12'(lo);
      e.fault = oor || (lo > LIMIT);
    end else if (op == 2'b11) begin
      e.wb    = 12'(lo);
      e.fault = oor || (int'(base) > LIMIT) || (lo > LIMIT);
    end
    e.wben = (op == 2'b11) && !e.fault;
    return e;
  endfunction

  // Monitor: compares the DUT against the model mid-cycle, then advances the model for the coming edge.
  always @(negedge clk) begin
    bit acc;
    bit emt;
    if (chk_en) begin
      n_cmp++;
      if (out_valid !== (sb.size() != 0)) begin
        n_bad++;
        $display("[TB] FAIL out_valid: got %0b expected %0b at %0t", out_valid, sb.size() != 0, $time);
      end
      n_cmp++;
      if (in_ready !== (sb.size() < 2)) begin
        n_bad++;
        $display("[TB] FAIL in_ready: got %0b expected %0b at %0t", in_ready, sb.size() < 2, $time);
      end
      n_cmp++;
      if (fault_cnt !== 8'(exp_fcnt)) begin
        n_bad++;
        $display("[TB] FAIL fault_cnt: got %0d expected %0d at %0t", fault_cnt, exp_fcnt, $time);
      end
      if (sb.size() != 0) begin
        n_cmp++;
        if ({pc_out, op_out, addr_out, wb_out, wb_en_out, fault_out} !==
            {sb[0].pc, sb[0].op, sb[0].addr, sb[0].wb, sb[0].wben, sb[0].fault}) begin
          n_bad++;
          $display("[TB] FAIL head: got pc=%h op=%0d addr=%h wb=%h wben=%0b flt=%0b expected pc=%h op=%0d addr=%h wb=%h wben=%0b flt=%0b at %0t",
                   pc_out, op_out, addr_out, wb_out, wb_en_out, fault_out,
                   sb[0].pc, sb[0].op, sb[0].addr, sb[0].wb, sb[0].wben, sb[0].fault, $time);
        end
      end
    end

    acc = in_valid && (sb.size() < 2);
    emt = out_ready && (sb.size() != 0);
    if (!rst) begin
      sb.delete();
      exp_fcnt = 0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (emt) void'(sb.pop_front());
      if (acc) begin
        exp_t e;
        e = model(pc_in, op_in, base_in, off_in);
        sb.push_back(e);
        if (e.fault && exp_fcnt < 255) exp_fcnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] base,
                       input logic [7:0] off, input logic [11:0] pc);
    in_valid = v;
    op_in    = op;
    base_in  = base;
    off_in   = off;
    pc_in    = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 12'h123, 8'h04, 12'h0AA);
    repeat (3) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || fault_cnt !== 8'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_hold: got out_valid=%0b fault_cnt=%0d expected 0/0", out_valid, fault_cnt);
    end
    rst = 1'b1;
    drive(1'b0, 2'b00, 12'h000, 8'h00, 12'h000);
    n_cmp++;
    if ({in_ready, pc_out, op_out, addr_out, wb_out, wb_en_out, fault_out} !== {1'b1, 40'd0}) begin
      n_bad++;
      $display("[TB] FAIL reset_values: got in_ready=%0b pc=%h addr=%h wb=%h expected 1/0/0/0",
               in_ready, pc_out, addr_out, wb_out);
    end
    chk_en = 1'b1;
    tick();
  endtask

  task automatic test_load();
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 12'h100, 8'hFC, 12'h010);
    tick();
    drive(1'b0, 2'b00, 12'h000, 8'h00, 12'h000);
    n_cmp++;
    if (out_valid !== 1'b1 || addr_out !== 12'h0FC || fault_out !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL load: got valid=%0b addr=%h fault=%0b expected 1/0fc/0", out_valid, addr_out, fault_out);
    end
    tick();
  endtask

  task automatic test_postinc();
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 12'h200, 8'h10, 12'h014);
    tick();
    drive(1'b0, 2'b00, 12'h000, 8'h00, 12'h000);
    n_cmp++;
    if (addr_out !== 12'h200 || wb_out !== 12'h210 || wb_en_out !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL postinc: got addr=%h wb=%h wb_en=%0b expected 200/210/1", addr_out, wb_out, wb_en_out);
    end
    tick();
  endtask

  task automatic test_fault();
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 12'h002, 8'hFD, 12'h018);
    tick();
    drive(1'b1, 2'b01, 12'h7F0, 8'h20, 12'h01C);
    n_cmp++;
    if (fault_out !== 1'b1 || fault_cnt !== 8'd1) begin
      n_bad++;
      $display("[TB] FAIL store_wrap: got fault=%0b cnt=%0d expected 1/1", fault_out, fault_cnt);
    end
    tick();
    drive(1'b0, 2'b00, 12'h000, 8'h00, 12'h000);
    n_cmp++;
    if (fault_out !== 1'b1 || fault_cnt !== 8'd2 || addr_out !== 12'h810) begin
      n_bad++;
      $display("[TB] FAIL load_limit: got fault=%0b cnt=%0d addr=%h expected 1/2/810", fault_out, fault_cnt, addr_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 12'h300, 8'h01, 12'h011);
    tick();
    drive(1'b1, 2'b10, 12'h400, 8'h02, 12'h022);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL b2b_ready1: got %0b expected 1", in_ready);
    end
    tick();
    drive(1'b1, 2'b11, 12'h500, 8'h03, 12'h033);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL b2b_full: got in_ready=%0b expected 0", in_ready);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b0 || pc_out !== 12'h011) begin
      n_bad++;
      $display("[TB] FAIL b2b_hold: got in_ready=%0b pc=%h expected 0/011", in_ready, pc_out);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (pc_out !== 12'h022 || in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL b2b_second: got pc=%h in_ready=%0b expected 022/1", pc_out, in_ready);
    end
    tick();
    drive(1'b0, 2'b00, 12'h000, 8'h00, 12'h000);
    n_cmp++;
    if (pc_out !== 12'h033 || addr_out !== 12'h500 || wb_out !== 12'h503) begin
      n_bad++;
      $display("[TB] FAIL b2b_third: got pc=%h addr=%h wb=%h expected 033/500/503", pc_out, addr_out, wb_out);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL b2b_drain: got out_valid=%0b pending=%0d expected 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_flush();
    int cnt_before;
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 12'h010, 8'h00, 12'h041);
    tick();
    cnt_before = int'(fault_cnt);
    drive(1'b1, 2'b01, 12'hF00, 8'h00, 12'h042);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || int'(fault_cnt) != cnt_before) begin
      n_bad++;
      $display("[TB] FAIL flush_one: got valid=%0b ready=%0b cnt=%0d expected 0/1/%0d",
               out_valid, in_ready, fault_cnt, cnt_before);
    end
    drive(1'b1, 2'b01, 12'hF00, 8'h00, 12'h043);
    tick();
    drive(1'b1, 2'b10, 12'h020, 8'h00, 12'h044);
    tick();
    cnt_before = int'(fault_cnt);
    n_cmp++;
    if (in_ready !== 1'b0 || cnt_before != exp_fcnt) begin
      n_bad++;
      $display("[TB] FAIL flush_pre: got ready=%0b cnt=%0d expected 0/%0d", in_ready, cnt_before, exp_fcnt);
    end
    drive(1'b1, 2'b01, 12'hF00, 8'h00, 12'h045);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 12'h000, 8'h00, 12'h000);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || int'(fault_cnt) != cnt_before) begin
      n_bad++;
      $display("[TB] FAIL flush_two: got valid=%0b ready=%0b cnt=%0d expected 0/1/%0d",
               out_valid, in_ready, fault_cnt, cnt_before);
    end
    tick();
  endtask

  task automatic test_soak();
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)),
            8'($urandom), 12'(i));
      out_ready = $urandom_range(0, 9) < 6;
      flush = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 12'h000, 8'h00, 12'h000);
    repeat (4) tick();
    n_cmp++;
    if (sb.size() != 0 || fault_cnt !== 8'd255) begin
      n_bad++;
      $display("[TB] FAIL soak_end: got pending=%0d cnt=%0d expected 0/255", sb.size(), fault_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    chk_en = 1'b0;
    exp_fcnt = 0;
    test_reset();
    test_load();
    test_postinc();
    test_fault();
    test_back_to_back();
    test_flush();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
